fx_master: RTL

Byte-stream to fx-bus bridge: the initiator end of the fx register bus. It parses command packets from the host byte link (USB/FX2 byte FIFO side), issues `fx_wr` / `fx_rd` transactions to all fx slaves, and returns read data on an outbound byte stream. Slave `fx_q` outputs are OR-combined upstream; non-selected slaves drive 0.

---
 rtl/fx_pkg.sv | 36 +++
 rtl/fx_master.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fx_pkg.sv
// Shared definitions for the fx register bus: command codes, address width,
// address-field positions used by every slave, and the bridge state encoding.
package fx_pkg;

  localparam logic [7:0] FX_CMD_WR = 8'h57;
  localparam logic [7:0] FX_CMD_RD = 8'h52;
  localparam int unsigned FX_AW = 16;

  // Address fields: module id selects the slave, register selects inside it.
  localparam int unsigned FX_MOD_MSB = 13;
  localparam int unsigned FX_MOD_LSB = 8;
  localparam int unsigned FX_REG_MSB = 7;
  localparam int unsigned FX_REG_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN,
    ST_WDATA,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_SEND
  } fx_state_e;

  // Module id field of an fx address.
  function automatic logic [FX_MOD_MSB-FX_MOD_LSB:0] fx_mod_id(input logic [FX_AW-1:0] addr);
    return addr[FX_MOD_MSB:FX_MOD_LSB];
  endfunction

  // Register field of an fx address.
  function automatic logic [FX_REG_MSB-FX_REG_LSB:0] fx_reg_id(input logic [FX_AW-1:0] addr);
    return addr[FX_REG_MSB:FX_REG_LSB];
  endfunction

endpackage

// File: rtl/fx_master.sv
// fx_master: host byte-stream to fx register bus initiator. Parses
// CMD/ADDR_H/ADDR_L/LEN packets, issues fx_wr / fx_rd transactions with
// auto-incrementing address, and returns read bytes on the tx stream.
module fx_master
  import fx_pkg::*;
#(
  parameter int unsigned RD_LAT = 1  // fx_rd cycle to fx_q valid cycle, 1..7
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_vld,
  output logic             rx_rdy,
  output logic [7:0]       tx_data,
  output logic             tx_vld,
  input  logic             tx_rdy,
  output logic [FX_AW-1:0] fx_waddr,
  output logic             fx_wr,
  output logic [7:0]       fx_data,
  output logic [FX_AW-1:0] fx_raddr,
  output logic             fx_rd,
  input  logic [7:0]       fx_q,
  output logic             busy,
  output logic             cmd_err
);

  // RD_WAIT lasts RD_LAT cycles; the counter starts at RD_LAT-1 and fx_q is
  // sampled in the cycle the counter reads zero.
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  fx_state_e        state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [FX_AW-1:0] addr_q, addr_d;
  logic [8:0]       count_q, count_d;   // 9 bits so LEN=0 can mean 256
  logic [2:0]       wait_q, wait_d;
  logic [FX_AW-1:0] fx_waddr_q, fx_waddr_d;
  logic [FX_AW-1:0] fx_raddr_q, fx_raddr_d;
  logic [7:0]       fx_data_q, fx_data_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             fx_wr_q, fx_wr_d;
  logic             fx_rd_q, fx_rd_d;
  logic             tx_vld_q, tx_vld_d;
  logic             cmd_err_q, cmd_err_d;

  logic             rx_state;
  logic             rx_fire;

  // Inbound acceptance: open in the parse and write states, and forced shut
  // during reset so the host never sees a byte taken that is then dropped.
  assign rx_state = (state_q inside {ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_LEN, ST_WDATA});
  assign rx_rdy   = rx_state & ~rst;
  assign rx_fire  = rx_vld & rx_rdy;

  // Next-state, datapath and strobe computation.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wait_d     = wait_q;
    fx_waddr_d = fx_waddr_q;
    fx_data_d  = fx_data_q;
    tx_data_d  = tx_data_q;
    fx_wr_d    = 1'b0;
    cmd_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (rx_data == FX_CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = ST_ADDR_H;
          end else if (rx_data == FX_CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = ST_ADDR_H;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_ADDR_H: begin
        if (rx_fire) begin
          addr_d[15:8] = rx_data;
          state_d      = ST_ADDR_L;
        end
      end
      ST_ADDR_L: begin
        if (rx_fire) begin
          addr_d[7:0] = rx_data;
          state_d     = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_fire) begin
          count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = is_wr_q ? ST_WDATA : ST_RD_ISSUE;
        end
      end
      ST_WDATA: begin
        if (rx_fire) begin
          fx_wr_d    = 1'b1;
          fx_waddr_d = addr_q;
          fx_data_d  = rx_data;
          addr_d     = addr_q + FX_AW'(1);
          count_d    = count_q - 9'd1;
          if (count_q == 9'd1) state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        wait_d  = WAIT_INIT;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wait_q == 3'd0) begin
          tx_data_d = fx_q;
          state_d   = ST_RD_SEND;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_RD_SEND: begin
        if (tx_rdy) begin
          addr_d  = addr_q + FX_AW'(1);
          count_d = count_q - 9'd1;
          state_d = (count_q == 9'd1) ? ST_IDLE : ST_RD_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read strobe and tx valid track the state being entered, so they are
    // registered yet high exactly while in RD_ISSUE / RD_SEND.
    fx_rd_d    = (state_d == ST_RD_ISSUE);
    fx_raddr_d = fx_rd_d ? addr_d : fx_raddr_q;
    tx_vld_d   = (state_d == ST_RD_SEND);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      fx_waddr_q <= '0;
      fx_raddr_q <= '0;
      fx_data_q  <= '0;
      tx_data_q  <= '0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      tx_vld_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      fx_waddr_q <= fx_waddr_d;
      fx_raddr_q <= fx_raddr_d;
      fx_data_q  <= fx_data_d;
      tx_data_q  <= tx_data_d;
      fx_wr_q    <= fx_wr_d;
      fx_rd_q    <= fx_rd_d;
      tx_vld_q   <= tx_vld_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign fx_waddr = fx_waddr_q;
  assign fx_wr    = fx_wr_q;
  assign fx_data  = fx_data_q;
  assign fx_raddr = fx_raddr_q;
  assign fx_rd    = fx_rd_q;
  assign tx_data  = tx_data_q;
  assign tx_vld   = tx_vld_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
